pipe_stage_reg: RTL and testbench

//  Generic pipeline stage register for the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, stall,
// flush/bubble insertion and an optional skid slot.
// The control field reads as zero whenever the stage holds no valid
// instruction, so a bubble never triggers downstream side effects.
module pipe_stage_reg #(
    parameter int CTRL_W   = 8,
    parameter int DATA_W   = 64,
    parameter int NUM_DATA = 5,
    parameter int SKID     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            ctrl_in,
    input  logic [NUM_DATA*DATA_W-1:0]   data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            ctrl_out,
    output logic [NUM_DATA*DATA_W-1:0]   data_out
);

    localparam int PW = NUM_DATA * DATA_W;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [PW-1:0]       data_q, data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [PW-1:0]       skid_data_q, skid_data_d;
    logic                accept;
    logic                drain;

    assign out_valid = (state_q != EMPTY);
    assign ctrl_out  = ctrl_q;
    assign data_out  = data_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Upstream ready: combinational pass-through without a skid slot,
    // purely registered (state-derived) when the skid slot exists.
    always_comb begin
        if (SKID != 0) begin
            in_ready = (state_q != SKID_FULL);
        end else begin
            in_ready = out_ready | ~out_valid;
        end
    end

    // Next-state and slot contents; flush overrides every transition.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            ctrl_d      = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        ctrl_d  = ctrl_in;
                        data_d  = data_in;
                    end
                end
                FULL: begin
                    if (drain && accept) begin
                        ctrl_d = ctrl_in;
                        data_d = data_in;
                    end else if (drain) begin
                        // Bubble: control cleared, data left as-is.
                        state_d = EMPTY;
                        ctrl_d  = '0;
                    end else if (accept && (SKID != 0)) begin
                        state_d     = SKID_FULL;
                        skid_ctrl_d = ctrl_in;
                        skid_data_d = data_in;
                    end
                end
                SKID_FULL: begin
                    if (drain) begin
                        state_d     = FULL;
                        ctrl_d      = skid_ctrl_q;
                        data_d      = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

    // State and slot registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one instance without and one with
// the skid slot, sharing stimulus. Accepted instructions are queued per
// instance; a monitor compares outputs against the queue head.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 64;
    localparam int ND = 5;
    localparam int PW = ND * DW;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [PW-1:0] d;
    } item_t;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] ctrl_in;
    logic [PW-1:0] data_in;

    logic          in_ready  [2];
    logic          out_valid [2];
    logic [CW-1:0] ctrl_out  [2];
    logic [PW-1:0] data_out  [2];

    item_t         exp_mem [2][16];
    int unsigned   wp [2];
    int unsigned   rp [2];
    logic [PW-1:0] last_d [2];

    int unsigned   checks;
    int unsigned   passes;
    int unsigned   sz;
    logic          exp_rdy;
    item_t         head;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NUM_DATA(ND), .SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .ctrl_in(ctrl_in), .data_in(data_in),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .ctrl_out(ctrl_out[0]), .data_out(data_out[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NUM_DATA(ND), .SKID(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .ctrl_in(ctrl_in), .data_in(data_in),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .ctrl_out(ctrl_out[1]), .data_out(data_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [PW-1:0] rand_data();
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < PW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: compare outputs against the expected queue at mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sz = wp[i] - rp[i];
            if (!reset) begin
                chk($sformatf("u%0d reset valid", i), PW'(out_valid[i]), '0);
                chk($sformatf("u%0d reset ctrl", i), PW'(ctrl_out[i]), '0);
                chk($sformatf("u%0d reset data", i), data_out[i], '0);
                rp[i] = wp[i];
                last_d[i] = '0;
            end else begin
                chk($sformatf("u%0d out_valid", i), PW'(out_valid[i]), PW'(sz != 0));
                exp_rdy = (i == 0) ? (out_ready || sz == 0) : (sz < 2);
                chk($sformatf("u%0d in_ready", i), PW'(in_ready[i]), PW'(exp_rdy));
                if (sz != 0) begin
                    head = exp_mem[i][rp[i] % 16];
                    chk($sformatf("u%0d ctrl_out", i), PW'(ctrl_out[i]), PW'(head.c));
                    chk($sformatf("u%0d data_out", i), data_out[i], head.d);
                    last_d[i] = head.d;
                    if (out_ready) rp[i] = rp[i] + 1;
                end else begin
                    chk($sformatf("u%0d bubble ctrl", i), PW'(ctrl_out[i]), '0);
                    chk($sformatf("u%0d bubble data", i), data_out[i], last_d[i]);
                end
                if (flush) rp[i] = wp[i];
            end
        end
    end

    // Record accepted instructions just after the monitor has run.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (reset && !flush && in_valid && in_ready[i]) begin
                exp_mem[i][wp[i] % 16] = {ctrl_in, data_in};
                wp[i] = wp[i] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] ch0);
        in_valid = v;
        ctrl_in  = c;
        data_in  = rand_data();
        data_in[DW-1:0] = ch0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        for (int i = 0; i < 2; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            last_d[i] = '0;
        end
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 8'h3C, 64'hDEAD);
        repeat (3) tick();
        reset = 1'b1;
        set_in(1'b0, 8'h00, 64'h0);
        tick();

        // Back-to-back stream
        set_in(1'b1, 8'hA5, 64'h1); tick();
        set_in(1'b1, 8'hA5, 64'h2); tick();
        set_in(1'b0, 8'h00, 64'h0); repeat (2) tick();

        // Stall for three cycles at FULL, then release
        set_in(1'b1, 8'h11, 64'h3); tick();
        out_ready = 1'b0;
        set_in(1'b1, 8'h22, 64'h4); repeat (3) tick();
        out_ready = 1'b1;
        set_in(1'b0, 8'h00, 64'h0); repeat (3) tick();

        // Flush with a pending accept while full / skid full
        out_ready = 1'b0;
        set_in(1'b1, 8'h33, 64'h5); tick();
        set_in(1'b1, 8'h44, 64'h6); tick();
        flush = 1'b1;
        set_in(1'b1, 8'h55, 64'h7); tick();
        flush = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 8'h00, 64'h0); repeat (2) tick();

        // Bubble after a single instruction
        set_in(1'b1, 8'h66, 64'h8); tick();
        set_in(1'b0, 8'h00, 64'h0); repeat (2) tick();

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            set_in($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 2999) != 0);
            tick();
        end
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
